delta_arbiter: RTL and testbench

- Collects per-channel PID delta updates from N_CHAN independent producers and serialises them onto the single dv/chan/delta stream that feeds output_filter.
- Holds one pending delta per channel. Coalesces back-to-back updates by saturating addition. Grants channels round-robin.
- Guarantees periodic idle cycles so output_filter can inject initial values.
- Configured over the shared wr_en/wr_addr/wr_chan/wr_data bus. Address constants come from ep_map.vh.

---
 rtl/delta_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_delta_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_arbiter.sv
// delta_arbiter
//   Collects per-channel PID delta updates from N_CHAN producers and
//   serialises them onto a single dv/chan/delta stream for output_filter.
//   Each channel holds one pending delta; a new update arriving while one is
//   still pending is folded in by saturating addition. Pending channels are
//   granted round-robin, and after IDLE_PERIOD consecutive issue cycles one
//   idle cycle is forced so the consumer can inject initial values.
//
// Ports
//   clk_in    : system clock
//   rst_in    : asynchronous active-high reset
//   dv_in     : per-channel delta valid strobes
//   delta_in  : packed signed deltas, channel i at [i*W_DELTA +: W_DELTA]
//   wr_en     : config write strobe
//   wr_addr   : config address (ARB_EN_ADDR / ARB_OVF_CLR_ADDR)
//   wr_chan   : config target channel (writes to channels >= N_CHAN ignored)
//   wr_data   : config data (bit 0 used for the enable register)
//   dv_out    : registered delta valid
//   chan_out  : registered granted channel
//   delta_out : registered granted delta
//   ovf_out   : sticky per-channel coalesce-saturation flags
//
// ARB_EN_ADDR / ARB_OVF_CLR_ADDR must be set to the values in ep_map.vh.
module delta_arbiter #(
  parameter int W_CHAN      = 5,
  parameter int N_CHAN      = 8,
  parameter int W_DELTA     = 18,
  parameter int IDLE_PERIOD = 16,
  parameter int W_WR_ADDR   = 16,
  parameter int W_WR_CHAN   = 5,
  parameter int W_WR_DATA   = 48,
  parameter logic [W_WR_ADDR-1:0] ARB_EN_ADDR      = W_WR_ADDR'(16'h0040),
  parameter logic [W_WR_ADDR-1:0] ARB_OVF_CLR_ADDR = W_WR_ADDR'(16'h0041)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [N_CHAN-1:0]           dv_in,
  input  logic [N_CHAN*W_DELTA-1:0]   delta_in,
  input  logic                        wr_en,
  input  logic [W_WR_ADDR-1:0]        wr_addr,
  input  logic [W_WR_CHAN-1:0]        wr_chan,
  input  logic [W_WR_DATA-1:0]        wr_data,
  output logic                        dv_out,
  output logic [W_CHAN-1:0]           chan_out,
  output logic [W_DELTA-1:0]          delta_out,
  output logic [N_CHAN-1:0]           ovf_out
);

  localparam int W_IDX  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int W_IDLE = (IDLE_PERIOD > 0) ? $clog2(IDLE_PERIOD + 1) : 1;
  localparam logic [W_DELTA-1:0] D_MAX = {1'b0, {(W_DELTA-1){1'b1}}};
  localparam logic [W_DELTA-1:0] D_MIN = {1'b1, {(W_DELTA-1){1'b0}}};

  // Signed saturating add; returns {clipped, result}.
  function automatic logic [W_DELTA:0] sat_add(input logic [W_DELTA-1:0] a,
                                               input logic [W_DELTA-1:0] b);
    logic [W_DELTA:0] sum;
    logic [W_DELTA:0] res;
    sum = {a[W_DELTA-1], a} + {b[W_DELTA-1], b};
    // Sign bits disagree only when the true sum left the W_DELTA range.
    if (sum[W_DELTA] != sum[W_DELTA-1]) begin
      res = {1'b1, (sum[W_DELTA] ? D_MIN : D_MAX)};
    end else begin
      res = {1'b0, sum[W_DELTA-1:0]};
    end
    return res;
  endfunction

  // State registers and next-state values
  logic [N_CHAN-1:0]  pend_q, pend_d;
  logic [W_DELTA-1:0] hold_q [N_CHAN];
  logic [W_DELTA-1:0] hold_d [N_CHAN];
  logic [N_CHAN-1:0]  en_q, en_d;
  logic [N_CHAN-1:0]  ovf_q, ovf_d;
  logic [W_IDX-1:0]   ptr_q, ptr_d;
  logic [W_IDLE-1:0]  idle_cnt_q, idle_cnt_d;
  logic               dv_q, dv_d;
  logic [W_CHAN-1:0]  chan_q, chan_d;
  logic [W_DELTA-1:0] delta_q, delta_d;

  // Combinational helpers
  logic [N_CHAN-1:0]  cand_s;
  logic               found_s;
  logic [W_IDX-1:0]   win_s;
  logic [W_IDX:0]     scan_s;
  logic               force_idle_s;
  logic               issue_s;
  logic               wr_ok_s;
  logic [W_IDX-1:0]   wr_idx_s;
  logic [W_DELTA:0]   sat_s;
  logic               unused_wr_data_s;

  assign unused_wr_data_s = ^wr_data[W_WR_DATA-1:1];

  assign cand_s       = pend_q & en_q;
  assign force_idle_s = (IDLE_PERIOD > 0) && (idle_cnt_q == W_IDLE'(IDLE_PERIOD));
  assign issue_s      = found_s && !force_idle_s;
  assign wr_ok_s      = wr_en && (32'(wr_chan) < N_CHAN);
  assign wr_idx_s     = wr_chan[W_IDX-1:0];

  // Round-robin winner: first candidate at or above ptr, wrapping mod N_CHAN.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    scan_s  = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      scan_s = {1'b0, ptr_q} + (W_IDX+1)'(k);
      if (scan_s >= (W_IDX+1)'(N_CHAN)) begin
        scan_s = scan_s - (W_IDX+1)'(N_CHAN);
      end else begin
        scan_s = scan_s;
      end
      if (!found_s && cand_s[scan_s[W_IDX-1:0]]) begin
        found_s = 1'b1;
        win_s   = scan_s[W_IDX-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next state: issue, capture/coalesce, then config writes.
  always_comb begin
    pend_d     = pend_q;
    hold_d     = hold_q;
    en_d       = en_q;
    ovf_d      = ovf_q;
    ptr_d      = ptr_q;
    idle_cnt_d = '0;
    dv_d       = 1'b0;
    chan_d     = chan_q;
    delta_d    = delta_q;
    sat_s      = '0;

    if (issue_s) begin
      dv_d           = 1'b1;
      chan_d         = W_CHAN'(win_s);
      delta_d        = hold_q[win_s];
      pend_d[win_s]  = 1'b0;
      ptr_d          = (win_s == W_IDX'(N_CHAN - 1)) ? '0 : win_s + W_IDX'(1);
      idle_cnt_d     = (IDLE_PERIOD > 0) ? idle_cnt_q + W_IDLE'(1) : '0;
    end else begin
      dv_d       = 1'b0;
      idle_cnt_d = '0;
    end

    // Clear first so a same-cycle saturation below wins.
    if (wr_ok_s && (wr_addr == ARB_OVF_CLR_ADDR)) begin
      ovf_d[wr_idx_s] = 1'b0;
    end else begin
      ovf_d[wr_idx_s] = ovf_q[wr_idx_s];
    end

    for (int i = 0; i < N_CHAN; i++) begin
      if (dv_in[i] && en_q[i]) begin
        // A channel granted this cycle frees its slot, so it reloads.
        if (!pend_q[i] || (issue_s && (win_s == W_IDX'(i)))) begin
          hold_d[i] = delta_in[i*W_DELTA +: W_DELTA];
        end else begin
          sat_s     = sat_add(hold_q[i], delta_in[i*W_DELTA +: W_DELTA]);
          hold_d[i] = sat_s[W_DELTA-1:0];
          ovf_d[i]  = ovf_d[i] | sat_s[W_DELTA];
        end
        pend_d[i] = 1'b1;
      end else begin
        pend_d[i] = pend_d[i];
      end
    end

    // Disabling a channel discards its pending delta so no stale value
    // can surface after re-enable.
    if (wr_ok_s && (wr_addr == ARB_EN_ADDR)) begin
      en_d[wr_idx_s] = wr_data[0];
      if (!wr_data[0]) begin
        pend_d[wr_idx_s] = 1'b0;
        hold_d[wr_idx_s] = '0;
      end else begin
        pend_d[wr_idx_s] = pend_d[wr_idx_s];
      end
    end else begin
      en_d[wr_idx_s] = en_q[wr_idx_s];
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_q     <= '0;
      en_q       <= '1;
      ovf_q      <= '0;
      ptr_q      <= '0;
      idle_cnt_q <= '0;
      dv_q       <= 1'b0;
      chan_q     <= '0;
      delta_q    <= '0;
      for (int i = 0; i < N_CHAN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      ptr_q      <= ptr_d;
      idle_cnt_q <= idle_cnt_d;
      dv_q       <= dv_d;
      chan_q     <= chan_d;
      delta_q    <= delta_d;
      for (int i = 0; i < N_CHAN; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign dv_out    = dv_q;
  assign chan_out  = chan_q;
  assign delta_out = delta_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_delta_arbiter.sv
// Testbench for delta_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the arbiter.
module tb_delta_arbiter;

  localparam int N    = 8;
  localparam int WD   = 18;
  localparam int WC   = 5;
  localparam int IDLE = 4;
  localparam int DMAX = (1 << (WD - 1)) - 1;
  localparam int DMIN = -(1 << (WD - 1));
  localparam logic [15:0] EN_A  = 16'h0040;
  localparam logic [15:0] CLR_A = 16'h0041;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [N-1:0]      dv_in = '0;
  logic [N*WD-1:0]   delta_in = '0;
  logic              wr_en = 1'b0;
  logic [15:0]       wr_addr = '0;
  logic [4:0]        wr_chan = '0;
  logic [47:0]       wr_data = '0;
  logic              dv_out;
  logic [WC-1:0]     chan_out;
  logic [WD-1:0]     delta_out;
  logic [N-1:0]      ovf_out;

  int dl [N];

  // Reference model state
  bit m_pend [N];
  bit m_en   [N];
  bit m_ovf  [N];
  int m_hold [N];
  int m_ptr, m_idle;
  bit e_dv;
  int e_chan, e_delta;

  int n_vec = 0;
  int n_err = 0;

  delta_arbiter #(
    .W_CHAN(WC), .N_CHAN(N), .W_DELTA(WD), .IDLE_PERIOD(IDLE),
    .W_WR_ADDR(16), .W_WR_CHAN(5), .W_WR_DATA(48),
    .ARB_EN_ADDR(EN_A), .ARB_OVF_CLR_ADDR(CLR_A)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .dv_in(dv_in), .delta_in(delta_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data),
    .dv_out(dv_out), .chan_out(chan_out), .delta_out(delta_out), .ovf_out(ovf_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_en[i] = 1; m_ovf[i] = 0; m_hold[i] = 0;
    end
    m_ptr = 0; m_idle = 0; e_dv = 0; e_chan = 0; e_delta = 0;
  endtask

  task automatic model_step();
    bit op [N];
    bit oe [N];
    int win;
    bit issue;
    int s;
    op = m_pend;
    oe = m_en;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (win < 0 && op[c] && oe[c]) win = c;
    end
    issue = (win >= 0) && !(IDLE > 0 && m_idle == IDLE);
    if (issue) begin
      e_dv = 1; e_chan = win; e_delta = m_hold[win];
      m_pend[win] = 0; m_ptr = (win + 1) % N; m_idle++;
    end else begin
      e_dv = 0; m_idle = 0;
    end
    if (wr_en && wr_chan < N && wr_addr == CLR_A) m_ovf[wr_chan] = 0;
    for (int i = 0; i < N; i++) begin
      if (dv_in[i] && oe[i]) begin
        if (!op[i] || (issue && win == i)) begin
          m_hold[i] = dl[i];
        end else begin
          s = m_hold[i] + dl[i];
          if (s > DMAX) begin s = DMAX; m_ovf[i] = 1; end
          if (s < DMIN) begin s = DMIN; m_ovf[i] = 1; end
          m_hold[i] = s;
        end
        m_pend[i] = 1;
      end
    end
    if (wr_en && wr_chan < N && wr_addr == EN_A) begin
      m_en[wr_chan] = wr_data[0];
      if (!wr_data[0]) begin
        m_pend[wr_chan] = 0; m_hold[wr_chan] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  ov;
    logic [WD-1:0] ed;
    for (int i = 0; i < N; i++) ov[i] = m_ovf[i];
    ed = e_delta[WD-1:0];
    check_val("dv_out", 64'(dv_out), 64'(e_dv));
    check_val("chan_out", 64'(chan_out), 64'(e_chan));
    check_val("delta_out", 64'(delta_out), 64'(ed));
    check_val("ovf_out", 64'(ovf_out), 64'(ov));
  endtask

  task automatic clear_inputs();
    dv_in = '0; wr_en = 1'b0; wr_addr = '0; wr_chan = '0; wr_data = '0;
    for (int i = 0; i < N; i++) dl[i] = 0;
    delta_in = '0;
  endtask

  // One clock: present inputs, step the model at the edge, compare after it.
  task automatic cycle();
    for (int i = 0; i < N; i++) delta_in[i*WD +: WD] = dl[i][WD-1:0];
    @(posedge clk_in);
    if (rst_in) model_reset();
    else model_step();
    #1;
    compare_all();
    clear_inputs();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
  endtask

  task automatic cfg_write(input logic [15:0] a, input logic [4:0] c, input logic [47:0] d);
    wr_en = 1'b1; wr_addr = a; wr_chan = c; wr_data = d;
  endtask

  initial begin
    logic [WD-1:0] neg9;
    bit seen;
    neg9 = 18'h3FFF7;
    model_reset();
    clear_inputs();
    #2;
    do_reset();
    check_val("rst_dv", 64'(dv_out), 64'd0);
    check_val("rst_ovf", 64'(ovf_out), 64'd0);

    // Single request, minimum latency
    dv_in[3] = 1'b1; dl[3] = 100;
    cycle();
    check_val("lat_early", 64'(dv_out), 64'd0);
    cycle();
    check_val("lat_dv", 64'(dv_out), 64'd1);
    check_val("lat_chan", 64'(chan_out), 64'd3);
    check_val("lat_delta", 64'(delta_out), 64'd100);
    cycle();
    check_val("lat_after", 64'(dv_out), 64'd0);

    // Full backlog with forced idle after IDLE grants
    do_reset();
    dv_in = '1;
    for (int i = 0; i < N; i++) dl[i] = i + 1;
    cycle();
    for (int k = 0; k < 9; k++) begin
      cycle();
      if (k == 4) begin
        check_val("ff_idle", 64'(dv_out), 64'd0);
      end else begin
        check_val("ff_chan", 64'(chan_out), 64'((k < 4) ? k : k - 1));
        check_val("ff_delta", 64'(delta_out), 64'((k < 4) ? k + 1 : k));
      end
    end

    // Coalescing and saturation
    do_reset();
    dv_in[1] = 1'b1; dl[1] = 11; dv_in[2] = 1'b1; dl[2] = 5;
    cycle();
    dv_in[2] = 1'b1; dl[2] = 7;
    cycle();
    cycle();
    check_val("coal_chan", 64'(chan_out), 64'd2);
    check_val("coal_delta", 64'(delta_out), 64'd12);
    dv_in[1] = 1'b1; dl[1] = 131000; dv_in[2] = 1'b1; dl[2] = 131000;
    cycle();
    dv_in[2] = 1'b1; dl[2] = 2000;
    cycle();
    check_val("ovf2_set", 64'(ovf_out[2]), 64'd1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (dv_out && chan_out == 5'd2) begin
        check_val("sat_delta", 64'(delta_out), 64'd131071);
        seen = 1;
        break;
      end
    end
    if (!seen) check_val("sat_grant_seen", 64'd0, 64'd1);
    cfg_write(CLR_A, 5'd2, 48'd0);
    cycle();
    check_val("ovf2_clr", 64'(ovf_out[2]), 64'd0);

    // Pointer wrap: ptr = 5, pending {1,6}
    do_reset();
    dv_in[4] = 1'b1; dl[4] = 44;
    cycle();
    cycle();
    dv_in[1] = 1'b1; dl[1] = 21; dv_in[6] = 1'b1; dl[6] = 66;
    cycle();
    cycle();
    check_val("wrap_first", 64'(chan_out), 64'd6);
    cycle();
    check_val("wrap_second", 64'(chan_out), 64'd1);

    // Continuous requests on every channel
    for (int k = 0; k < 24; k++) begin
      dv_in = '1;
      for (int i = 0; i < N; i++) dl[i] = 10 * i + k;
      cycle();
    end
    for (int k = 0; k < 12; k++) cycle();

    // Disable while pending, ignored request, re-enable with fresh value
    do_reset();
    dv_in[0] = 1'b1; dl[0] = 10; dv_in[4] = 1'b1; dl[4] = 40;
    cycle();
    cfg_write(EN_A, 5'd4, 48'd0);
    cycle();
    dv_in[4] = 1'b1; dl[4] = 77;
    cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_val("dis_no_ch4", 64'(dv_out && chan_out == 5'd4), 64'd0);
    end
    cfg_write(EN_A, 5'd4, 48'd1);
    cycle();
    dv_in[4] = 1'b1; dl[4] = -9;
    cycle();
    cycle();
    check_val("reen_chan", 64'(chan_out), 64'd4);
    check_val("reen_delta", 64'(delta_out), 64'(neg9));

    // Asynchronous reset mid-backlog
    dv_in = '1;
    for (int i = 0; i < N; i++) dl[i] = i + 50;
    cycle();
    cycle();
    check_val("pre_rst_dv", 64'(dv_out), 64'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check_val("async_rst_dv", 64'(dv_out), 64'd0);
    model_reset();
    cycle();
    rst_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_val("post_rst_quiet", 64'(dv_out), 64'd0);
    end

    // Out-of-range channel write must not disable channel 1
    cfg_write(EN_A, 5'd9, 48'd0);
    cycle();
    dv_in = '1;
    for (int i = 0; i < N; i++) dl[i] = -i;
    cycle();
    for (int k = 0; k < 10; k++) cycle();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      dv_in = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0)
          dl[i] = int'($urandom_range(0, 2 * DMAX + 1)) + DMIN;
        else
          dl[i] = int'($urandom_range(0, 200)) - 100;
      end
      if ($urandom_range(0, 5) == 0) begin
        wr_en   = 1'b1;
        wr_chan = 5'($urandom_range(0, 15));
        wr_data = {16'($urandom), 32'($urandom)};
        case ($urandom_range(0, 2))
          0: begin wr_addr = EN_A; wr_data[0] = ($urandom_range(0, 3) != 0); end
          1: wr_addr = CLR_A;
          default: wr_addr = 16'h0042;
        endcase
      end
      rst_in = ($urandom_range(0, 499) == 0);
      cycle();
      rst_in = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
